multiplexador_display: RTL and testbench

MULTIPLEXADOR_DISPLAY -- requirements
Module: multiplexador_display

---
 rtl/multiplexador_display.sv | 153 +++++++++++++++
 tb/tb_multiplexador_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multiplexador_display.sv
// Four-digit multiplexed seven-segment display driver.
//
// It scans four BCD digits one at a time. A prescaler holds each digit lit for
// DIVISOR enabled cycles. New values are loaded into a pending register. They
// are copied to the displayed (active) register only at a frame boundary, so
// the display never tears mid-scan.
//
// Ports:
//   clock        rising-edge clock for all state
//   reset        synchronous, active-high reset
//   enable       scan advance enable; 0 freezes the scan
//   carga        load strobe; samples digitos on the same edge
//   digitos      four BCD digits, [15:12] = most significant
//   apaga_zeros  1 = blank leading zeros (digit 0 is never blanked)
//   anodo        one-hot active-high digit select
//   segmentos    active-high segments, [6]=a .. [0]=g
//   pendente     a loaded value is waiting for the next frame boundary
//   atualizado   one-cycle pulse when the displayed value is replaced
module multiplexador_display #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        carga,
  input  logic [15:0] digitos,
  input  logic        apaga_zeros,
  output logic [3:0]  anodo,
  output logic [6:0]  segmentos,
  output logic        pendente,
  output logic        atualizado
);

  localparam logic [15:0] CntLast = 16'(DIVISOR - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] active_q, active_d;
  logic [15:0] pend_q, pend_d;
  logic        pendente_q, pendente_d;
  logic        atualizado_q, atualizado_d;
  logic [3:0]  anodo_q, anodo_d;
  logic [6:0]  seg_q, seg_d;

  logic        wrap;
  logic        frame_end;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap      = enable && (cnt_q == CntLast);
    frame_end = wrap && (idx_q == 2'd3);

    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    end
    idx_d = wrap ? idx_q + 2'd1 : idx_q;

    active_d     = active_q;
    pend_d       = pend_q;
    pendente_d   = pendente_q;
    atualizado_d = 1'b0;
    if (frame_end) begin
      // A load on the boundary cycle bypasses the pending register.
      if (carga) begin
        active_d = digitos;
      end else if (pendente_q) begin
        active_d = pend_q;
      end
      atualizado_d = carga | pendente_q;
      pendente_d   = 1'b0;
    end else if (carga) begin
      pend_d     = digitos;
      pendente_d = 1'b1;
    end

    // Decode from active_d so digit 0 at a boundary already shows the new value.
    nib   = active_d[3:0];
    blank = 1'b0;
    unique case (idx_d)
      2'd0: begin
        nib   = active_d[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = active_d[7:4];
        blank = apaga_zeros && (active_d[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = active_d[11:8];
        blank = apaga_zeros && (active_d[15:8] == 8'd0);
      end
      default: begin
        nib   = active_d[15:12];
        blank = apaga_zeros && (active_d[15:12] == 4'd0);
      end
    endcase

    anodo_d = anodo_q;
    seg_d   = seg_q;
    if (wrap) begin
      anodo_d = 4'b0001 << idx_d;
      seg_d   = blank ? 7'b0000000 : decode(nib);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= 16'd0;
      idx_q        <= 2'd0;
      active_q     <= 16'd0;
      pend_q       <= 16'd0;
      pendente_q   <= 1'b0;
      atualizado_q <= 1'b0;
      anodo_q      <= 4'b0001;
      seg_q        <= 7'b1111110;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pendente_q   <= pendente_d;
      atualizado_q <= atualizado_d;
      anodo_q      <= anodo_d;
      seg_q        <= seg_d;
    end
  end

  assign anodo      = anodo_q;
  assign segmentos  = seg_q;
  assign pendente   = pendente_q;
  assign atualizado = atualizado_q;

endmodule

// File: tb/tb_multiplexador_display.sv
// Self-checking bench for multiplexador_display.
// The main instance uses DIVISOR=4. A second instance uses DIVISOR=1 and
// checks that its scan advances on every enabled cycle.
module tb_multiplexador_display;

  localparam int Div   = 4;
  localparam int Frame = 4 * Div;

  logic        clock = 1'b0;
  logic        reset, enable, carga, apaga_zeros;
  logic [15:0] digitos;
  logic [3:0]  anodo, anodo1;
  logic [6:0]  segmentos, segmentos1;
  logic        pendente, atualizado, pendente1, atualizado1;

  always #5 clock = ~clock;

  multiplexador_display #(.DIVISOR(Div)) dut (
    .clock(clock), .reset(reset), .enable(enable), .carga(carga), .digitos(digitos),
    .apaga_zeros(apaga_zeros), .anodo(anodo), .segmentos(segmentos),
    .pendente(pendente), .atualizado(atualizado)
  );

  multiplexador_display #(.DIVISOR(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .carga(carga), .digitos(digitos),
    .apaga_zeros(apaga_zeros), .anodo(anodo1), .segmentos(segmentos1),
    .pendente(pendente1), .atualizado(atualizado1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the frame counted in enabled cycles.
  logic [6:0] seg_tab [16];
  int         m_t, m_t1;
  int         m_active, m_pend;
  bit         m_pendf, m_atual;
  int         m_anodo, m_seg;

  function automatic int digit_seg(int val, int i, bit apz);
    int d;
    d = (val >> (4 * i)) % 16;
    if (apz && i > 0 && (val >> (4 * i)) == 0) return 0;
    return int'(seg_tab[d]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit ld, input int dig,
                            input bit apz);
    if (rst) begin
      m_t = 0; m_t1 = 0; m_active = 0; m_pend = 0; m_pendf = 0; m_atual = 0;
      m_anodo = 1; m_seg = int'(seg_tab[0]);
      return;
    end
    m_atual = 0;
    if (en && m_t == Frame - 1) begin
      if (ld) m_active = dig;
      else if (m_pendf) m_active = m_pend;
      m_atual = ld || m_pendf;
      m_pendf = 0;
    end else if (ld) begin
      m_pend = dig;
      m_pendf = 1;
    end
    if (en) begin
      m_t  = (m_t + 1) % Frame;
      m_t1 = (m_t1 + 1) % 4;
      if (m_t % Div == 0) begin
        m_anodo = 1 << (m_t / Div);
        m_seg   = digit_seg(m_active, m_t / Div, apz);
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ld, input logic [15:0] dig,
                      input bit apz);
    reset = rst; enable = en; carga = ld; digitos = dig; apaga_zeros = apz;
    @(posedge clock);
    model_edge(rst, en, ld, int'(dig), apz);
    #1;
    chk("anodo", int'(anodo), m_anodo);
    chk("segmentos", int'(segmentos), m_seg);
    chk("pendente", int'(pendente), int'(m_pendf));
    chk("atualizado", int'(atualizado), int'(m_atual));
    chk("anodo_div1", int'(anodo1), 1 << m_t1);
  endtask

  typedef struct {
    logic [15:0] dig;
    bit          apz;
    logic [6:0]  s [4];
  } vec_t;

  vec_t vecs [9];

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
    vecs[0] = '{16'h1234, 1'b0, '{7'h33, 7'h79, 7'h6D, 7'h30}};
    vecs[1] = '{16'h0050, 1'b1, '{7'h7E, 7'h5B, 7'h00, 7'h00}};
    vecs[2] = '{16'h9999, 1'b0, '{7'h7B, 7'h7B, 7'h7B, 7'h7B}};
    vecs[3] = '{16'h0000, 1'b1, '{7'h7E, 7'h00, 7'h00, 7'h00}};
    vecs[4] = '{16'h0000, 1'b0, '{7'h7E, 7'h7E, 7'h7E, 7'h7E}};
    vecs[5] = '{16'hABCD, 1'b1, '{7'h01, 7'h01, 7'h01, 7'h01}};
    vecs[6] = '{16'h5678, 1'b0, '{7'h7F, 7'h70, 7'h5F, 7'h5B}};
    vecs[7] = '{16'h0105, 1'b1, '{7'h5B, 7'h7E, 7'h30, 7'h00}};
    vecs[8] = '{16'h0009, 1'b1, '{7'h7B, 7'h00, 7'h00, 7'h00}};

    reset = 1'b1; enable = 1'b0; carga = 1'b0; digitos = '0; apaga_zeros = 1'b0;

    // Reset pulse, with enable and carga asserted to prove they are overridden.
    step(1, 1, 1, 16'hFFFF, 0);
    chk("rst_anodo", int'(anodo), 1);
    chk("rst_seg", int'(segmentos), 'h7E);
    chk("rst_pendente", int'(pendente), 0);

    // Load 1234 at cycle 2; it must wait for the frame boundary at cycle 16.
    for (int c = 0; c < 16; c++) begin
      step(0, 1, c == 2, 16'h1234, 0);
      if (c == 3) chk("pend_c3", int'(pendente), 1);
      if (c == 14) chk("still_zero", int'(segmentos), 'h7E);
    end
    chk("bnd_atual", int'(atualizado), 1);
    chk("bnd_anodo", int'(anodo), 1);
    chk("bnd_seg", int'(segmentos), 'h33);
    step(0, 1, 0, 16'h0, 0);
    chk("atual_once", int'(atualizado), 0);
    for (int c = 0; c < 3; c++) step(0, 1, 0, 16'h0, 0);
    chk("d1_anodo", int'(anodo), 2);
    chk("d1_seg", int'(segmentos), 'h79);

    // Freeze mid-digit for 10 cycles, loading a value while frozen.
    step(0, 1, 0, 16'h0, 0);
    for (int c = 0; c < 10; c++) begin
      step(0, 0, c == 4, 16'h4321, 0);
      chk("frozen_anodo", int'(anodo), 2);
    end
    for (int c = 0; c < 2; c++) step(0, 1, 0, 16'h0, 0);
    chk("resume_hold", int'(anodo), 2);
    step(0, 1, 0, 16'h0, 0);
    chk("resume_adv", int'(anodo), 4);

    // A pending value is discarded by a reset mid-frame.
    step(0, 1, 1, 16'h7777, 0);
    step(1, 1, 0, 16'h0, 0);
    for (int c = 0; c < Frame + 2; c++) step(0, 1, 0, 16'h0, 0);
    chk("discard_seg", int'(segmentos), 'h7E);

    // Decode table: each value is loaded exactly on the boundary cycle.
    for (int v = 0; v < 9; v++) begin
      int guard = 0;
      while (m_t != Frame - 1 && guard < 64) begin
        step(0, 1, 0, 16'h0, vecs[v].apz);
        guard++;
      end
      if (guard >= 64) chk("boundary_timeout", guard, 0);
      step(0, 1, 1, vecs[v].dig, vecs[v].apz);
      chk("tab_atual", int'(atualizado), 1);
      chk("tab_pend", int'(pendente), 0);
      chk("tab_d0", int'(segmentos), int'(vecs[v].s[0]));
      for (int d = 1; d < 4; d++) begin
        for (int c = 0; c < Div; c++) step(0, 1, 0, 16'h0, vecs[v].apz);
        chk("tab_anodo", int'(anodo), 1 << d);
        chk("tab_seg", int'(segmentos), int'(vecs[v].s[d]));
      end
    end

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] dig;
      for (int k = 0; k < 4; k++) dig[4*k +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0
                                                 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 10, dig, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
